// File: rtl/sm_debug_pkg.sv
// Shared definitions for the schoolMIPS debug controller.
//   mode_e       : controller mode, also presented on the mode output
//   STEP_CNT_W   : width of the saturating clkEnable cycle counter
//   STEP_CNT_MAX : saturation value of that counter
package sm_debug_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } mode_e;

  localparam int                    STEP_CNT_W   = 16;
  localparam logic [STEP_CNT_W-1:0] STEP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sm_debounce.sv
// Button debouncer with registered rising-edge press pulse.
//   clk   : system clock
//   rst   : synchronous reset, active-high
//   in    : raw button level, active-high
//   level : debounced stable level
//   press : one-cycle pulse on the cycle level goes 0->1
module sm_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = cnt_q;
    if (in == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Raw input has disagreed for DEB_CYCLES edges: accept the new level.
      level_d = ~level_q;
      press_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/sm_debug_ctrl.sv
// Run/halt/single-step controller and register-scan sequencer for schoolMIPS.
//   clk, rst   : system clock, synchronous active-high reset
//   btnRun     : raw run/halt toggle button
//   btnStep    : raw single-step button
//   clkEnable  : clock enable to the core (registered)
//   mode       : current mode (HALT/RUN/STEP), also the FSM state
//   regAddr    : debug register address driven to the core
//   regData    : debug register data from the core (combinational from regAddr)
//   dispAddr   : address of the last captured register
//   dispData   : value of the last captured register
//   dispValid  : one-cycle strobe when dispAddr/dispData update
//   stepCount  : saturating count of cycles with clkEnable=1
//
// Handshake: dispValid is a one-cycle valid with no ready; the consumer must
// take dispAddr/dispData on the cycle dispValid is high. Both stay stable
// until the next strobe.
module sm_debug_ctrl
  import sm_debug_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int DEB_CYCLES = 50000,
  parameter int SCAN_HOLD  = 1000000,
  parameter int RESET_RUN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btnRun,
  input  logic                  btnStep,
  output logic                  clkEnable,
  output logic [1:0]            mode,
  output logic [REG_ADDR_W-1:0] regAddr,
  input  logic [31:0]           regData,
  output logic [REG_ADDR_W-1:0] dispAddr,
  output logic [31:0]           dispData,
  output logic                  dispValid,
  output logic [STEP_CNT_W-1:0] stepCount
);

  localparam int                    HOLD_W    = $clog2(SCAN_HOLD);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);
  localparam logic [HOLD_W-1:0]     HOLD_ONE  = HOLD_W'(1);
  localparam logic [REG_ADDR_W-1:0] ADDR_ONE  = REG_ADDR_W'(1);
  localparam logic [STEP_CNT_W-1:0] STEP_ONE  = STEP_CNT_W'(1);
  localparam mode_e                 RST_MODE  = (RESET_RUN != 0) ? RUN : HALT;

  // Button conditioning
  logic run_level, run_press;
  logic step_level, step_press;

  sm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk   (clk),
    .rst   (rst),
    .in    (btnRun),
    .level (run_level),
    .press (run_press)
  );

  sm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk   (clk),
    .rst   (rst),
    .in    (btnStep),
    .level (step_level),
    .press (step_press)
  );

  // Only the press pulses drive the FSM; the stable levels are not needed here.
  logic unused_levels;
  assign unused_levels = run_level ^ step_level;

  // Mode FSM
  mode_e state_q, state_d;
  logic  clk_en_q, clk_en_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_MODE;
      clk_en_q <= (RESET_RUN != 0);
    end else begin
      state_q  <= state_d;
      clk_en_q <= clk_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HALT: begin
        // A simultaneous run press wins and the step is dropped.
        if (run_press)       state_d = RUN;
        else if (step_press) state_d = STEP;
      end
      RUN: begin
        if (run_press) state_d = HALT;
      end
      STEP: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // clkEnable registers the next-state decision, so a STEP visit yields
  // exactly one enabled cycle.
  always_comb begin
    clk_en_d = (state_d == RUN) || (state_d == STEP);
    mode     = state_q;
  end

  assign clkEnable = clk_en_q;

  // Saturating enabled-cycle counter
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;

  always_comb begin
    step_cnt_d = step_cnt_q;
    if (clk_en_q && (step_cnt_q != STEP_CNT_MAX)) begin
      step_cnt_d = step_cnt_q + STEP_ONE;
    end
  end

  // Register scan sequencer, free-running regardless of mode
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [REG_ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [31:0]           disp_data_q, disp_data_d;
  logic                  disp_valid_q, disp_valid_d;

  always_comb begin
    hold_d       = hold_q + HOLD_ONE;
    reg_addr_d   = reg_addr_q;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    if (hold_q == HOLD_LAST) begin
      // regAddr has been stable for SCAN_HOLD cycles: capture, then advance.
      hold_d       = '0;
      disp_data_d  = regData;
      disp_addr_d  = reg_addr_q;
      disp_valid_d = 1'b1;
      reg_addr_d   = reg_addr_q + ADDR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q   <= '0;
      hold_q       <= '0;
      reg_addr_q   <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      step_cnt_q   <= step_cnt_d;
      hold_q       <= hold_d;
      reg_addr_q   <= reg_addr_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign stepCount = step_cnt_q;
  assign regAddr   = reg_addr_q;
  assign dispAddr  = disp_addr_q;
  assign dispData  = disp_data_q;
  assign dispValid = disp_valid_q;

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// Directed bench for sm_debug_ctrl with DEB_CYCLES=4, SCAN_HOLD=8.
// dut runs with RESET_RUN=1, dut2 with RESET_RUN=0.
module tb_sm_debug_ctrl;

  // Clock / reset
  logic clk = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;

  logic        btnRun, btnStep;
  logic        clkEnable, clkEnable2;
  logic [1:0]  mode, mode2;
  logic [3:0]  regAddr, regAddr2, dispAddr, dispAddr2;
  logic [31:0] regData, regData2, dispData, dispData2;
  logic        dispValid, dispValid2;
  logic [15:0] stepCount, stepCount2;

  assign regData  = {28'h0, regAddr};
  assign regData2 = {28'h0, regAddr2};

  sm_debug_ctrl #(.REG_ADDR_W(4), .DEB_CYCLES(4), .SCAN_HOLD(8), .RESET_RUN(1)) dut (
    .clk(clk), .rst(rst), .btnRun(btnRun), .btnStep(btnStep),
    .clkEnable(clkEnable), .mode(mode), .regAddr(regAddr), .regData(regData),
    .dispAddr(dispAddr), .dispData(dispData), .dispValid(dispValid),
    .stepCount(stepCount)
  );

  sm_debug_ctrl #(.REG_ADDR_W(4), .DEB_CYCLES(4), .SCAN_HOLD(8), .RESET_RUN(0)) dut2 (
    .clk(clk), .rst(rst2), .btnRun(1'b0), .btnStep(1'b0),
    .clkEnable(clkEnable2), .mode(mode2), .regAddr(regAddr2), .regData(regData2),
    .dispAddr(dispAddr2), .dispData(dispData2), .dispValid(dispValid2),
    .stepCount(stepCount2)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mode"},  32'(mode), 32'd1);
    check({tag, "_clken"}, 32'(clkEnable), 32'd1);
    check({tag, "_scnt"},  32'(stepCount), 32'd0);
    check({tag, "_raddr"}, 32'(regAddr), 32'd0);
    check({tag, "_daddr"}, 32'(dispAddr), 32'd0);
    check({tag, "_ddata"}, dispData, 32'd0);
    check({tag, "_dvld"},  32'(dispValid), 32'd0);
  endtask

  initial begin
    int en_cnt;
    logic saw_step;
    int n;

    btnRun = 1'b0; btnStep = 1'b0;
    rst = 1'b1; rst2 = 1'b1;
    @(negedge clk);
    ticks(2);

    // 1. Reset values, then free run
    check_reset_vals("rst");
    check("rst2_mode",  32'(mode2), 32'd0);
    check("rst2_clken", 32'(clkEnable2), 32'd0);
    rst = 1'b0; rst2 = 1'b0;
    tick();
    check("run_first_clken", 32'(clkEnable), 32'd1);
    check("run_first_scnt",  32'(stepCount), 32'd1);
    ticks(19);
    check("run20_mode", 32'(mode), 32'd1);
    check("run20_scnt", 32'(stepCount), 32'd20);
    check("halt2_mode",  32'(mode2), 32'd0);
    check("halt2_clken", 32'(clkEnable2), 32'd0);
    check("halt2_scnt",  32'(stepCount2), 32'd0);
    check("halt2_raddr", 32'(regAddr2), 32'd2);

    // 2. Short glitch on run is filtered; a long press toggles once
    btnRun = 1'b1; ticks(3);
    btnRun = 1'b0; ticks(5);
    check("glitch_mode", 32'(mode), 32'd1);
    check("glitch_scnt", 32'(stepCount), 32'd28);
    btnRun = 1'b1; ticks(6);
    check("runpress_mode",  32'(mode), 32'd0);
    check("runpress_clken", 32'(clkEnable), 32'd0);
    check("runpress_scnt",  32'(stepCount), 32'd33);
    btnRun = 1'b0; ticks(10);
    check("halt_mode", 32'(mode), 32'd0);
    check("halt_scnt", 32'(stepCount), 32'd33);

    // 3. Single steps from HALT
    for (int p = 0; p < 2; p++) begin
      en_cnt = 0; saw_step = 1'b0;
      btnStep = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (clkEnable) en_cnt++;
        if (mode == 2'd2) saw_step = 1'b1;
      end
      check("step_en_cycles", 32'(en_cnt), 32'd1);
      check("step_seen",      32'(saw_step), 32'd1);
      check("step_mode_after", 32'(mode), 32'd0);
      check("step_scnt", 32'(stepCount), 32'(34 + p));
      btnStep = 1'b0; ticks(6);
    end

    // 4. Simultaneous run and step: run wins
    saw_step = 1'b0;
    btnRun = 1'b1; btnStep = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mode == 2'd2) saw_step = 1'b1;
    end
    check("both_no_step", 32'(saw_step), 32'd0);
    check("both_mode",    32'(mode), 32'd1);
    check("both_clken",   32'(clkEnable), 32'd1);
    check("both_scnt",    32'(stepCount), 32'd36);
    btnRun = 1'b0; btnStep = 1'b0; ticks(6);

    // 5. Register scan across the address wrap
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int k = 1; k <= 136; k++) begin
      tick();
      check("scan_valid", 32'(dispValid), 32'((k % 8) == 0));
      if ((k % 8) == 0) begin
        n = (k / 8) - 1;
        check("scan_daddr", 32'(dispAddr), 32'(n % 16));
        check("scan_ddata", dispData, 32'(n % 16));
        check("scan_raddr", 32'(regAddr), 32'((n + 1) % 16));
      end
    end

    // 6a. Reset during a STEP cycle
    btnRun = 1'b1; ticks(6);
    btnRun = 1'b0; ticks(6);
    check("pre_step_mode", 32'(mode), 32'd0);
    btnStep = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mode == 2'd2) break;
    end
    check("in_step_mode", 32'(mode), 32'd2);
    btnStep = 1'b0;
    rst = 1'b1; tick();
    check_reset_vals("rst_step");
    rst = 1'b0; tick();
    check("post_rst_mode", 32'(mode), 32'd1);
    check("post_rst_scnt", 32'(stepCount), 32'd1);

    // 6b. Reset mid-hold restarts the scan from address 0
    ticks(18);
    check("midhold_raddr", 32'(regAddr), 32'd2);
    check("midhold_daddr", 32'(dispAddr), 32'd1);
    check("midhold_ddata", dispData, 32'd1);
    rst = 1'b1; tick();
    check_reset_vals("rst_hold");
    rst = 1'b0;
    ticks(7);
    check("rehold_valid7", 32'(dispValid), 32'd0);
    tick();
    check("rehold_valid8", 32'(dispValid), 32'd1);
    check("rehold_daddr",  32'(dispAddr), 32'd0);
    check("rehold_raddr",  32'(regAddr), 32'd1);

    // 6c. stepCount saturation
    rst = 1'b1; tick();
    rst = 1'b0;
    ticks(65534);
    check("sat_fffe", 32'(stepCount), 32'h0000FFFE);
    tick();
    check("sat_ffff", 32'(stepCount), 32'h0000FFFF);
    ticks(5);
    check("sat_hold", 32'(stepCount), 32'h0000FFFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sm_debug_ctrl.md
Name: sm_debug_ctrl

Overview:
Run/halt/single-step controller and register-scan sequencer for the schoolMIPS core on the Marsohod2B board. It debounces two board buttons and drives the core's clkEnable. It also steps the core's debug register port (regAddr/regData) through every register address in turn. Each captured value is presented with a valid strobe to a display/UART consumer. It sits in the board top between the button pins and sm_top.

Parameters:
REG_ADDR_W, 4, width of the core debug register address.
DEB_CYCLES, 50000, consecutive stable cycles required to accept a button level change (≥2).
SCAN_HOLD, 1000000, cycles each regAddr is held before capture and advance (≥2).
RESET_RUN, 1, 1 = mode after reset is RUN; 0 = HALT.

Ports:
clk  in  1  system clock; the single clock of the block.
rst  in  1  synchronous reset, active-high.
btnRun  in  1  raw run/halt button, active-high (the top inverts board keys).
btnStep  in  1  raw single-step button, active-high.
clkEnable  out  1  clock enable to sm_top.
mode  out  2  0 = HALT, 1 = RUN, 2 = STEP.
regAddr  out  REG_ADDR_W  debug register address to sm_top.
regData  in  32  debug register data from sm_top; combinational from regAddr.
dispAddr  out  REG_ADDR_W  address of the last captured register.
dispData  out  32  value of the last captured register.
dispValid  out  1  one-cycle strobe when dispAddr/dispData update.
stepCount  out  16  number of cycles with clkEnable=1, saturating at 0xFFFF.

Behaviour:
- Everything is synchronous to clk. rst is sampled on the clk edge only.
- Reset values:
  - mode = RUN if RESET_RUN=1, else HALT.
  - clkEnable = (mode==RUN).
  - regAddr = 0, dispAddr = 0, dispData = 0, dispValid = 0, stepCount = 0.
  - Debouncer stable levels = 0 and counters = 0.
- Reset asserted mid-operation (for example during STEP or mid-hold) aborts immediately to the reset values. No pending step survives reset.
- Debounce, per button:
  - The counter resets to 0 whenever the raw input equals the stable level.
  - Otherwise the counter increments.
  - When the counter reaches DEB_CYCLES-1, the stable level flips and the counter clears.
  - A one-cycle press pulse is asserted on the cycle the stable level goes 0→1.
  - The press pulse is registered, so it appears DEB_CYCLES cycles after the raw edge.
- FSM states: HALT, RUN, STEP.
  - HALT: on runPress → RUN. On stepPress (without runPress) → STEP.
  - RUN: on runPress → HALT. stepPress is ignored.
  - STEP: unconditionally → HALT on the next cycle. Any press in that cycle is ignored.
  - If runPress and stepPress occur in the same cycle, runPress wins and the step is dropped.
- clkEnable is a registered output equal to (next state is RUN or STEP).
  - It rises the cycle after the transition decision.
  - One stepPress therefore produces exactly one clkEnable=1 cycle.
- stepCount increments on each cycle with clkEnable=1 and holds at 0xFFFF.
- Scan sequencer:
  - A hold counter runs 0..SCAN_HOLD-1 regardless of mode.
  - At count SCAN_HOLD-1: dispData ← regData, dispAddr ← regAddr, dispValid = 1 for the following cycle, and regAddr ← regAddr+1, wrapping modulo 2^REG_ADDR_W.
  - regAddr is therefore stable for SCAN_HOLD cycles before each capture.
  - The scan continues unchanged while the core is halted.
- dispValid is 0 in every other cycle.

Decomposition:
- Package sm_debug_pkg holds:
  - the mode enum (HALT=2'd0, RUN=2'd1, STEP=2'd2);
  - STEP_CNT_W=16 and STEP_CNT_MAX=16'hFFFF.
- Sub-module sm_debounce (parameter DEB_CYCLES; ports clk, rst, in, level, press), instantiated twice.
- The FSM, scan sequencer and step counter live in sm_debug_ctrl itself.

Test Plan (DEB_CYCLES=4, SCAN_HOLD=8, RESET_RUN=1 unless stated):
1. Reset, then 20 idle cycles → mode=RUN, clkEnable=1 from the first post-reset cycle, stepCount=20.
2. btnRun high for 3 cycles then low → no mode change. Held high for 6 cycles → exactly one toggle to HALT, clkEnable=0, stepCount frozen.
3. In HALT, btnStep held for 10 cycles → exactly one clkEnable=1 cycle, mode goes STEP then HALT, stepCount +1. A second press gives +1 again.
4. In HALT, btnRun and btnStep rise on the same cycle → mode=RUN, no STEP state entered.
5. regData driven as {28'h0, regAddr} → dispValid every 8 cycles with dispAddr 0,1,…,15,0 and dispData matching. The wrap from 15 to 0 is checked.
6. rst asserted during a STEP cycle and mid-hold; also RESET_RUN=0 → all outputs at reset values next cycle, regAddr=0, mode=HALT when RESET_RUN=0. Forcing stepCount to 0xFFFF then running 5 cycles → stays 0xFFFF.
